pll_lock_monitor: RTL and testbench

//  Consumes the q_sys PLL lock outputs (QSFP ATX x2, SDI ATX) and synchronises and debounces each one.

---
 rtl/pll_lock_monitor.sv | 212 +++++++++++++++++++++
 tb/tb_pll_lock_monitor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor
//   Synchronises and debounces the q_sys PLL lock outputs (QSFP ATX x2, SDI ATX),
//   counts lock-loss events per PLL and sequences the transceiver reset request.
//   xcvr_reset_req deasserts only after every PLL has held lock for RST_DELAY cycles.
//
//   Optional feature macro: PLL_LOCK_IRQ_EN (sticky lock-loss interrupt flop).
//
// Ports
//   clk_100_clk      in   system clock, all logic on this clock
//   reset_100_reset  in   synchronous active-high reset
//   pll_locked_in    in   [N_PLL]        raw lock bits, asynchronous
//   clear_counts     in   pulse, zero all loss counters
//   irq_clear        in   pulse, clear lock_irq
//   lock_status      out  [N_PLL]        debounced lock per PLL
//   all_locked       out  registered AND of lock_status
//   xcvr_reset_req   out  1 = hold transceivers in reset
//   loss_count       out  [N_PLL*CNT_W]  PLL i at [i*CNT_W +: CNT_W], saturating
//   lock_irq         out  sticky lock-loss flag (0 when PLL_LOCK_IRQ_EN undefined)
module pll_lock_monitor #(
  parameter int unsigned N_PLL       = 3,
  parameter int unsigned LOCK_CYCLES = 1000,
  parameter int unsigned RST_DELAY   = 256,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                     clk_100_clk,
  input  logic                     reset_100_reset,
  input  logic [N_PLL-1:0]         pll_locked_in,
  input  logic                     clear_counts,
  output logic [N_PLL-1:0]         lock_status,
  output logic                     all_locked,
  output logic                     xcvr_reset_req,
  output logic [N_PLL*CNT_W-1:0]   loss_count,
  output logic                     lock_irq,
  input  logic                     irq_clear
);

  localparam int unsigned LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int unsigned RCW = (RST_DELAY > 1) ? $clog2(RST_DELAY) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_DELAY - 1);

  typedef enum logic { UNLOCKED, LOCKED } pll_state_t;
  typedef enum logic { HOLD, RELEASED } rst_state_t;

  logic [N_PLL-1:0]       sync_meta;
  logic [N_PLL-1:0]       sync_q;

  pll_state_t             pll_state_q [N_PLL];
  pll_state_t             pll_state_d [N_PLL];
  logic [LCW-1:0]         lock_cnt_q  [N_PLL];
  logic [LCW-1:0]         lock_cnt_d  [N_PLL];
  logic [N_PLL-1:0]       loss_event;
  logic [N_PLL*CNT_W-1:0] loss_count_d;

  rst_state_t             rst_state_q;
  rst_state_t             rst_state_d;
  logic [RCW-1:0]         rcnt_q;
  logic [RCW-1:0]         rcnt_d;

  // 2-flop synchroniser per lock bit
  always_ff @(posedge clk_100_clk) begin
    if (reset_100_reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= pll_locked_in;
      sync_q    <= sync_meta;
    end
  end

  // Per-PLL debounce FSM
  always_ff @(posedge clk_100_clk) begin
    if (reset_100_reset) begin
      for (int unsigned i = 0; i < N_PLL; i++) begin
        pll_state_q[i] <= UNLOCKED;
        lock_cnt_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_PLL; i++) begin
        pll_state_q[i] <= pll_state_d[i];
        lock_cnt_q[i]  <= lock_cnt_d[i];
      end
    end
  end

  always_comb begin
    loss_event = '0;
    for (int unsigned i = 0; i < N_PLL; i++) begin
      pll_state_d[i] = pll_state_q[i];
      lock_cnt_d[i]  = lock_cnt_q[i];
      case (pll_state_q[i])
        UNLOCKED: begin
          if (sync_q[i]) begin
            if (lock_cnt_q[i] == LOCK_LAST) begin
              pll_state_d[i] = LOCKED;
              lock_cnt_d[i]  = '0;
            end else begin
              lock_cnt_d[i] = lock_cnt_q[i] + 1'b1;
            end
          end else begin
            lock_cnt_d[i] = '0;
          end
        end
        LOCKED: begin
          if (!sync_q[i]) begin
            pll_state_d[i] = UNLOCKED;
            lock_cnt_d[i]  = '0;
            loss_event[i]  = 1'b1;
          end
        end
        default: begin
          pll_state_d[i] = UNLOCKED;
          lock_cnt_d[i]  = '0;
        end
      endcase
    end
  end

  always_comb begin
    lock_status = '0;
    for (int unsigned i = 0; i < N_PLL; i++) begin
      lock_status[i] = (pll_state_q[i] == LOCKED);
    end
  end

  // Loss counters: clear is applied before the increment, then saturate
  always_comb begin
    loss_count_d = loss_count;
    for (int unsigned i = 0; i < N_PLL; i++) begin
      if (clear_counts) begin
        loss_count_d[i*CNT_W +: CNT_W] = '0;
      end
      if (loss_event[i] && (loss_count_d[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
        loss_count_d[i*CNT_W +: CNT_W] = loss_count_d[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_100_clk) begin
    if (reset_100_reset) begin
      loss_count <= '0;
      all_locked <= 1'b0;
    end else begin
      loss_count <= loss_count_d;
      all_locked <= &lock_status;
    end
  end

  // Transceiver reset sequencer
  always_ff @(posedge clk_100_clk) begin
    if (reset_100_reset) begin
      rst_state_q <= HOLD;
      rcnt_q      <= '0;
    end else begin
      rst_state_q <= rst_state_d;
      rcnt_q      <= rcnt_d;
    end
  end

  always_comb begin
    rst_state_d    = rst_state_q;
    rcnt_d         = rcnt_q;
    xcvr_reset_req = 1'b1;
    case (rst_state_q)
      HOLD: begin
        if (all_locked) begin
          if (rcnt_q == RST_LAST) begin
            rst_state_d = RELEASED;
            rcnt_d      = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end else begin
          rcnt_d = '0;
        end
      end
      RELEASED: begin
        xcvr_reset_req = 1'b0;
        if (!all_locked) begin
          rst_state_d = HOLD;
          rcnt_d      = '0;
        end
      end
      default: begin
        rst_state_d = HOLD;
        rcnt_d      = '0;
      end
    endcase
  end

`ifdef PLL_LOCK_IRQ_EN
  logic irq_q;

  // A new loss wins over a simultaneous clear
  always_ff @(posedge clk_100_clk) begin
    if (reset_100_reset) begin
      irq_q <= 1'b0;
    end else if (|loss_event) begin
      irq_q <= 1'b1;
    end else if (irq_clear) begin
      irq_q <= 1'b0;
    end
  end

  assign lock_irq = irq_q;
`else
  logic unused_irq_clear;
  assign unused_irq_clear = irq_clear;
  assign lock_irq = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Testbench for pll_lock_monitor (LOCK_CYCLES=16, RST_DELAY=8, N_PLL=3, CNT_W=8).
// The reference model describes lock as "run of consecutive synced-high samples
// has reached LOCK_CYCLES" and release as "run of all_locked samples has reached
// RST_DELAY"; it is compared against the DUT on every falling edge.
module tb_pll_lock_monitor;

  localparam int N  = 3;
  localparam int L  = 16;
  localparam int R  = 8;
  localparam int CW = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   pll_in = '0;
  logic           clear_counts = 1'b0;
  logic           irq_clear = 1'b0;
  logic [N-1:0]   lock_status;
  logic           all_locked;
  logic           xcvr_reset_req;
  logic [N*CW-1:0] loss_count;
  logic           lock_irq;

  int errors = 0;
  int checks = 0;

  pll_lock_monitor #(
    .N_PLL(N), .LOCK_CYCLES(L), .RST_DELAY(R), .CNT_W(CW)
  ) dut (
    .clk_100_clk(clk),
    .reset_100_reset(rst),
    .pll_locked_in(pll_in),
    .clear_counts(clear_counts),
    .lock_status(lock_status),
    .all_locked(all_locked),
    .xcvr_reset_req(xcvr_reset_req),
    .loss_count(loss_count),
    .lock_irq(lock_irq),
    .irq_clear(irq_clear)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [N-1:0] h1 = '0, h2 = '0;   // raw input seen 1 and 2 edges ago
  int  run  [N];
  int  lossm[N];
  bit  lock_m[N];
  int  arun = 0;
  bit  all_m = 0;
  bit  rel_m = 0;
  bit  irq_m = 0;
  bit  model_valid = 0;

  always @(posedge clk) begin
    bit any_loss;
    bit all_now;
    any_loss = 0;
    if (rst) begin
      h1 = '0; h2 = '0;
      for (int i = 0; i < N; i++) begin
        run[i] = 0; lossm[i] = 0; lock_m[i] = 0;
      end
      arun = 0; all_m = 0; rel_m = 0; irq_m = 0;
      model_valid = 1;
    end else begin
      arun  = all_m ? ((arun < R) ? arun + 1 : R) : 0;
      rel_m = (arun >= R);
      all_now = 1;
      for (int i = 0; i < N; i++) all_now = all_now & lock_m[i];
      all_m = all_now;
      for (int i = 0; i < N; i++) begin
        bit ev;
        ev = 0;
        if (h2[i]) run[i] = (run[i] < L) ? run[i] + 1 : L;
        else begin
          ev = (run[i] >= L);
          run[i] = 0;
        end
        lock_m[i] = (run[i] >= L);
        if (clear_counts) lossm[i] = 0;
        if (ev && lossm[i] < MAXC) lossm[i] = lossm[i] + 1;
        any_loss = any_loss | ev;
      end
`ifdef PLL_LOCK_IRQ_EN
      if (any_loss) irq_m = 1;
      else if (irq_clear) irq_m = 0;
`else
      irq_m = 0;
`endif
      h2 = h1;
      h1 = pll_in;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare process
  always @(negedge clk) begin
    if (model_valid) begin
      logic [N-1:0]    exp_ls;
      logic [N*CW-1:0] exp_lc;
      for (int i = 0; i < N; i++) begin
        exp_ls[i] = lock_m[i];
        exp_lc[i*CW +: CW] = CW'(lossm[i]);
      end
      chk("model.lock_status", 64'(lock_status), 64'(exp_ls));
      chk("model.all_locked", 64'(all_locked), 64'(all_m));
      chk("model.xcvr_reset_req", 64'(xcvr_reset_req), 64'(!rel_m));
      chk("model.loss_count", 64'(loss_count), 64'(exp_lc));
      chk("model.lock_irq", 64'(lock_irq), 64'(irq_m));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  function automatic logic [CW-1:0] lc(input int i);
    logic [N*CW-1:0] v;
    v = loss_count;
    return v[i*CW +: CW];
  endfunction

  initial begin
    int n, n_lock, n_all, n_rel;

    // Reset state
    pll_in = '0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.lock_status", 64'(lock_status), 64'd0);
    chk("reset.all_locked", 64'(all_locked), 64'd0);
    chk("reset.xcvr_reset_req", 64'(xcvr_reset_req), 64'd1);
    chk("reset.loss_count", 64'(loss_count), 64'd0);
    chk("reset.lock_irq", 64'(lock_irq), 64'd0);
    tick(1);

    // 1: steady lock, latencies counted from the edge before the input change
    pll_in = 3'b111;
    n = 0; n_lock = -1; n_all = -1; n_rel = -1;
    while (n < 60 && n_rel < 0) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (n_lock < 0 && lock_status == 3'b111) n_lock = n;
      if (n_all < 0 && all_locked) n_all = n;
      if (n_rel < 0 && !xcvr_reset_req) n_rel = n;
    end
    chk("t1.lock_latency", 64'(n_lock), 64'd18);
    chk("t1.all_latency", 64'(n_all), 64'd19);
    chk("t1.release_latency", 64'(n_rel), 64'd27);
    chk("t1.loss_count", 64'(loss_count), 64'd0);
    tick(1);

    // 2: PLL1 glitch shorter than LOCK_CYCLES
    pll_in = 3'b101;
    do_reset();
    pll_in[1] = 1'b1;
    tick(10);
    pll_in[1] = 1'b0;
    tick(30);
    chk("t2.lock_status", 64'(lock_status), 64'b101);
    chk("t2.xcvr_reset_req", 64'(xcvr_reset_req), 64'd1);
    chk("t2.loss1", 64'(lc(1)), 64'd0);

    // 3: one-cycle drop of PLL2 while released
    pll_in = 3'b111;
    tick(40);
    chk("t3.released", 64'(xcvr_reset_req), 64'd0);
    pll_in[2] = 1'b0;
    tick(1);
    pll_in[2] = 1'b1;
    tick(5);
    chk("t3.lock2", 64'(lock_status[2]), 64'd0);
    chk("t3.loss2", 64'(lc(2)), 64'd1);
    chk("t3.xcvr_reset_req", 64'(xcvr_reset_req), 64'd1);
`ifdef PLL_LOCK_IRQ_EN
    chk("t3.lock_irq", 64'(lock_irq), 64'd1);
`else
    chk("t3.lock_irq_tied", 64'(lock_irq), 64'd0);
`endif
    tick(40);
    chk("t3.rereleased", 64'(xcvr_reset_req), 64'd0);

    // 4: 300 loss events on PLL0, counter saturates
    for (int k = 0; k < 300; k++) begin
      pll_in[0] = 1'b0;
      tick(1);
      pll_in[0] = 1'b1;
      tick(17);
    end
    chk("t4.loss0_sat", 64'(lc(0)), 64'd255);
    chk("t4.loss1", 64'(lc(1)), 64'd0);
    chk("t4.loss2", 64'(lc(2)), 64'd1);

    // 5: clear_counts in the same cycle as a PLL0 loss
    pll_in[0] = 1'b0;
    tick(1);
    pll_in[0] = 1'b1;
    tick(1);
    clear_counts = 1'b1;
    tick(1);
    clear_counts = 1'b0;
    chk("t5.loss0_clear_inc", 64'(lc(0)), 64'd1);
    chk("t5.loss2_cleared", 64'(lc(2)), 64'd0);
    tick(20);
    irq_clear = 1'b1;
    tick(1);
    irq_clear = 1'b0;
    chk("t5.irq_cleared", 64'(lock_irq), 64'd0);
    pll_in[0] = 1'b0;
    tick(1);
    pll_in[0] = 1'b1;
    tick(1);
    irq_clear = 1'b1;
    tick(1);
    irq_clear = 1'b0;
`ifdef PLL_LOCK_IRQ_EN
    chk("t5.irq_set_wins", 64'(lock_irq), 64'd1);
`else
    chk("t5.irq_tied", 64'(lock_irq), 64'd0);
`endif

    // 6: reset during the RST_DELAY count
    tick(20);
    n = 0;
    while (n < 100 && !all_locked) begin
      tick(1); n++;
    end
    chk("t6.all_locked_seen", 64'(all_locked), 64'd1);
    tick(3);
    chk("t6.mid_release", 64'(xcvr_reset_req), 64'd1);
    rst = 1'b1;
    tick(1);
    chk("t6.lock_status", 64'(lock_status), 64'd0);
    chk("t6.all_locked", 64'(all_locked), 64'd0);
    chk("t6.xcvr_reset_req", 64'(xcvr_reset_req), 64'd1);
    chk("t6.loss_count", 64'(loss_count), 64'd0);
    chk("t6.lock_irq", 64'(lock_irq), 64'd0);
    rst = 1'b0;

    // Randomised phase, checked by the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < 4) pll_in[i] = ~pll_in[i];
      end
      clear_counts = ($urandom_range(0, 99) < 2);
      irq_clear    = ($urandom_range(0, 99) < 3);
      rst          = ($urandom_range(0, 999) < 2);
      tick(1);
    end
    clear_counts = 1'b0;
    irq_clear = 1'b0;
    rst = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
